// File: rtl/fifo_mem_pipe.sv
// Single-clock dual-port RAM with byte enables, pipelined read (latency 1 or 2),
// selectable read-during-write behaviour and a post-reset zero-fill sequencer.
module fifo_mem_pipe #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned PTR_WIDTH    = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RDW_MODE     = 1,
    localparam int unsigned BE_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  w_en_i,
    input  logic [PTR_WIDTH-1:0]  w_addr_i,
    input  logic [BE_WIDTH-1:0]   w_be_i,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    input  logic                  r_en_i,
    input  logic [PTR_WIDTH-1:0]  r_addr_i,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic                  r_valid_o,
    output logic                  r_collision_o,
    output logic                  init_busy_o
);

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("fifo_mem_pipe: DATA_WIDTH must be a multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("fifo_mem_pipe: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH < 2 || DEPTH > (2 ** PTR_WIDTH)) begin : g_bad_depth
        $error("fifo_mem_pipe: DEPTH out of range for PTR_WIDTH");
    end

    localparam logic [PTR_WIDTH-1:0] LastAddr = PTR_WIDTH'(DEPTH - 1);
    localparam logic [PTR_WIDTH:0]   DepthW   = (PTR_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e                 state_q;
    logic [PTR_WIDTH-1:0]   cnt_q;
    logic                   init_busy_q;
    logic                   ready;

    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic                   mem_we;
    logic [PTR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    logic [BE_WIDTH-1:0]    mem_be;

    logic                   w_in_range;
    logic                   r_in_range;
    logic                   rd_fire;
    logic                   rd_hit;
    logic [DATA_WIDTH-1:0]  rd_stored;
    logic [DATA_WIDTH-1:0]  rd_merged;
    logic [DATA_WIDTH-1:0]  rd_word;

    logic                   pipe_valid;
    logic                   pipe_coll;
    logic [DATA_WIDTH-1:0]  pipe_data;

    logic                   r_valid_q;
    logic                   r_coll_q;
    logic [DATA_WIDTH-1:0]  r_data_q;

    // Clear sequencer: counter walks 0..DEPTH-1 and parks there once READY.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            init_busy_q <= 1'b1;
        end else if (state_q == StInit) begin
            if (cnt_q == LastAddr) begin
                state_q     <= StReady;
                init_busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + PTR_WIDTH'(1);
            end
        end
    end

    assign ready      = (state_q == StReady);
    assign w_in_range = ({1'b0, w_addr_i} < DepthW);
    assign r_in_range = ({1'b0, r_addr_i} < DepthW);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = w_addr_i;
        mem_wdata = w_data_i;
        mem_be    = w_be_i;
        if (!rst_i) begin
            if (state_q == StInit) begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = '0;
                mem_be    = '1;
            end else begin
                mem_we = w_en_i & w_in_range;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < int'(BE_WIDTH); b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_fire   = ready & r_en_i & ~rst_i;
        rd_hit    = w_en_i & r_in_range & (w_addr_i == r_addr_i);
        rd_stored = r_in_range ? mem_q[r_addr_i] : '0;
        rd_merged = rd_stored;
        for (int b = 0; b < int'(BE_WIDTH); b++) begin
            if (w_be_i[b]) begin
                rd_merged[8*b +: 8] = w_data_i[8*b +: 8];
            end
        end
        rd_word = (rd_hit && RDW_MODE == 1) ? rd_merged : rd_stored;
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s1_valid_q;
        logic                  s1_coll_q;
        logic [DATA_WIDTH-1:0] s1_data_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                s1_valid_q <= 1'b0;
                s1_coll_q  <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= rd_fire;
                s1_coll_q  <= rd_fire & rd_hit;
                if (rd_fire) begin
                    s1_data_q <= rd_word;
                end
            end
        end

        assign pipe_valid = s1_valid_q;
        assign pipe_coll  = s1_coll_q;
        assign pipe_data  = s1_data_q;
    end else begin : g_lat1
        assign pipe_valid = rd_fire;
        assign pipe_coll  = rd_fire & rd_hit;
        assign pipe_data  = rd_word;
    end

    // r_data only moves on a valid beat so it holds between responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_q <= 1'b0;
            r_coll_q  <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= pipe_valid;
            r_coll_q  <= pipe_coll;
            if (pipe_valid) begin
                r_data_q <= pipe_data;
            end
        end
    end

    assign r_data_o      = r_data_q;
    assign r_valid_o     = r_valid_q;
    assign r_collision_o = r_coll_q;
    assign init_busy_o   = init_busy_q;

endmodule
